// File: rtl/flash_arb_pkg.sv
// Shared types and widths for the flash read arbiter.
package flash_arb_pkg;
  localparam int FL_ADDR_W = 23;
  localparam int FL_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} fa_state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N_REQ.
module rr_picker #(
  parameter  int N_REQ = 5,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_eff,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);
  int w_idx;

  // Scan farthest-first so the nearest candidate after ptr overwrites the rest.
  always_comb begin
    o_win = '0;
    o_any = |i_eff;
    w_idx = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = (int'(i_ptr) + i) % N_REQ;
      if (i_eff[w_idx]) o_win = IDX_W'(w_idx);
    end
  end
endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one read-only parallel NOR flash between N_REQ channels;
// one registered flash read is sequenced per grant.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int N_REQ    = 5,
  parameter int ADDR_W   = FL_ADDR_W,
  parameter int DATA_W   = FL_DATA_W,
  parameter int WAIT_CYC = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_enb,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [N_REQ-1:0]          o_valid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         FL_ADDR,
  output logic                      FL_CE_N,
  output logic                      FL_OE_N,
  output logic                      FL_WE_N,
  output logic                      FL_RST_N,
  output logic                      FL_WP_N,
  input  logic                      FL_RY,
  inout  wire  [DATA_W-1:0]         FL_DQ
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  fa_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt, w_win;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0]   r_valid, w_valid_nxt;
  logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_sel_n, w_sel_n_nxt;
  logic [N_REQ-1:0]   w_eff;
  logic               w_any;

  assign w_eff = i_req & i_enb;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .i_eff (w_eff),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = '0;
    w_rdata_nxt = r_rdata;
    w_addr_nxt  = r_addr;
    w_sel_n_nxt = r_sel_n;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_addr_nxt       = i_addr[w_win*ADDR_W +: ADDR_W];
          w_sel_n_nxt      = 1'b0;
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_ptr_nxt        = w_win;
          w_cnt_nxt        = CNT_W'(WAIT_CYC - 1);
          w_state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        // Counter parks at zero; a low FL_RY then stretches the access indefinitely.
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == '0 && FL_RY) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_rdata_nxt = FL_DQ;
        w_valid_nxt = r_gnt;
        w_sel_n_nxt = 1'b1;
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_valid <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_sel_n <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
      r_rdata <= w_rdata_nxt;
      r_addr  <= w_addr_nxt;
      r_sel_n <= w_sel_n_nxt;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_valid  = r_valid;
  assign o_rdata  = r_rdata;
  assign o_busy   = (r_state != IDLE);
  assign FL_ADDR  = r_addr;
  assign FL_CE_N  = r_sel_n;
  assign FL_OE_N  = r_sel_n;
  assign FL_WE_N  = 1'b1;
  assign FL_WP_N  = 1'b0;
  // Flash is held in reset exactly as long as the system is.
  assign FL_RST_N = i_rst_n;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench: a transaction-timing reference model predicts each read, a monitor checks it.
module tb_flash_read_arbiter;
  import flash_arb_pkg::*;
  localparam int N = 5, AW = 23, DW = 8, WC = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         enb, req;
  logic [N-1:0][AW-1:0] addr;
  logic                 ry;
  wire  [DW-1:0]        dq;
  logic [N-1:0]         o_gnt, o_valid;
  logic [DW-1:0]        o_rdata;
  logic                 o_busy, ce_n, oe_n, we_n, fl_rst_n, wp_n;
  logic [AW-1:0]        fl_addr;

  flash_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enb(enb), .i_req(req), .i_addr(addr),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_rdata(o_rdata), .o_busy(o_busy),
    .FL_ADDR(fl_addr), .FL_CE_N(ce_n), .FL_OE_N(oe_n), .FL_WE_N(we_n),
    .FL_RST_N(fl_rst_n), .FL_WP_N(wp_n), .FL_RY(ry), .FL_DQ(dq)
  );

  // Flash model: returns the low address byte while selected.
  assign dq = (!ce_n && !oe_n) ? fl_addr[7:0] : 8'h00;

  typedef struct {int ch; logic [7:0] data; int cyc;} exp_t;
  exp_t q[$];
  int   vlog[$], vcyc[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  bit   drv_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a grant is taken at the first free edge with any effective
  // request; data appears one edge after the first edge at least WAIT_CYC past the
  // grant on which FL_RY is high; the flash is free again the edge after that.
  bit             m_busy;
  int             m_ptr, m_win, m_ready, m_done;
  logic [AW-1:0]  m_addr;
  logic [N-1:0]   m_eff;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_ptr = N - 1; m_done = 0; q.delete();
    end else begin
      cyc++;
      if (!m_busy) begin
        m_eff = req & enb;
        if (|m_eff) begin
          for (int i = 1; i <= N; i++)
            if (m_eff[(m_ptr + i) % N]) begin m_win = (m_ptr + i) % N; break; end
          m_ptr = m_win; m_addr = addr[m_win];
          m_busy = 1'b1; m_ready = cyc + WC; m_done = 0;
        end
      end else if (m_done == 0) begin
        if (cyc >= m_ready && ry) begin
          m_done = cyc + 1;
          q.push_back('{m_win, m_addr[7:0], m_done});
        end
      end else if (cyc == m_done) m_busy = 1'b0;
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("gnt", o_gnt, m_busy ? (32'd1 << m_win) : 32'd0);
      chk("busy", o_busy, m_busy);
      chk("ce_oe_n", {ce_n, oe_n}, m_busy ? 2'b00 : 2'b11);
      if (m_busy) chk("fl_addr", fl_addr, m_addr);
      chk("static_pins", {we_n, wp_n, fl_rst_n}, 3'b101);
      if (o_valid != '0) begin
        if (q.size() == 0) chk("valid_unexpected", o_valid, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("valid_ch", o_valid, 32'd1 << e.ch);
          chk("rdata", o_rdata, e.data);
          chk("valid_cycle", cyc, e.cyc);
          for (int k = 0; k < N; k++) if (o_valid[k]) vlog.push_back(k);
          vcyc.push_back(cyc);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("valid_missing", 0, 32'd1 << q[0].ch);
        void'(q.pop_front());
      end
    end
  end

  // Randomized requesters: hold until o_valid, sometimes re-request, sometimes abandon.
  initial forever begin
    @(negedge clk);
    if (drv_en) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && o_valid[k]) req[k] = ($urandom_range(3) == 0);
        else if (!req[k]) begin
          if ($urandom_range(7) == 0) begin req[k] = 1'b1; addr[k] = AW'($urandom); end
        end else if ($urandom_range(63) == 0) req[k] = 1'b0;
        if ($urandom_range(15) == 0) addr[k] = AW'($urandom);
      end
      if ($urandom_range(31) == 0) enb = N'($urandom);
      ry = ($urandom_range(3) != 0);
    end
  end

  task automatic tick(); @(negedge clk); #1; endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    vlog.delete(); vcyc.delete();
  endtask

  task automatic wait_valids(input int n, input int lim);
    int t;
    t = 0;
    while (vlog.size() < n && t < lim) begin tick(); t++; end
    if (vlog.size() < n) chk("valid_timeout", vlog.size(), n);
  endtask

  int nt, nlow;
  initial begin
    enb = '1; req = '0; ry = 1'b1;
    for (int k = 0; k < N; k++) addr[k] = AW'(k * 16 + 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt_valid", {o_gnt, o_valid}, 0);
    chk("rst_rdata_busy", {o_rdata, o_busy}, 0);
    chk("rst_fl_addr", fl_addr, 0);
    chk("rst_ce_oe", {ce_n, oe_n}, 2'b11);
    chk("rst_pins", {we_n, wp_n, fl_rst_n}, 3'b100);
    rst_n = 1'b1;
    tick();

    // Single channel-2 read
    req[2] = 1'b1; addr[2] = 23'h000123;
    nt = 0; nlow = 0;
    while (vlog.size() == 0 && nt < 30) begin
      tick(); nt++;
      if (nt == 1) chk("t1_gnt", o_gnt, 5'b00100);
      if (!ce_n) nlow++;
    end
    req = '0;
    chk("t1_latency", nt, 6);
    chk("t1_ce_low", nlow, 5);
    chk("t1_rdata", o_rdata, 8'h23);
    repeat (4) tick();

    // All channels held
    do_reset();
    req = '1;
    wait_valids(6, 80);
    req = '0;
    if (vlog.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("t2_order", vlog[i], i % 5);
      for (int i = 1; i < 6; i++) chk("t2_spacing", vcyc[i] - vcyc[i-1], 6);
    end
    repeat (12) tick();

    // Channel 1 masked
    enb = 5'b11101;
    do_reset();
    req = '1;
    wait_valids(5, 80);
    req = '0;
    if (vlog.size() >= 5) begin
      chk("t3_o0", vlog[0], 0); chk("t3_o1", vlog[1], 2); chk("t3_o2", vlog[2], 3);
      chk("t3_o3", vlog[3], 4); chk("t3_o4", vlog[4], 0);
    end
    repeat (12) tick();
    enb = '1;

    // FL_RY stall of three cycles
    vlog.delete(); vcyc.delete();
    req[1] = 1'b1; addr[1] = 23'h0055AA;
    nt = 0;
    while (vlog.size() == 0 && nt < 30) begin
      tick(); nt++;
      if (nt == 1) ry = 1'b0;
      if (nt == 7) ry = 1'b1;
    end
    req = '0;
    chk("t4_latency", nt, 9);
    chk("t4_rdata", o_rdata, 8'hAA);
    repeat (4) tick();

    // Reset in the middle of an access
    req[4] = 1'b1; addr[4] = 23'h000077;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ce_oe", {ce_n, oe_n}, 2'b11);
    chk("t5_busy_gnt", {o_busy, o_gnt}, 0);
    chk("t5_fl_rst", fl_rst_n, 0);
    req = '1;
    tick(); tick();
    rst_n = 1'b1;
    vlog.delete(); vcyc.delete();
    wait_valids(1, 20);
    req = '0;
    if (vlog.size() >= 1) chk("t5_first_ch0", vlog[0], 0);
    repeat (12) tick();

    // Channel 3 drops its request after the grant
    vlog.delete(); vcyc.delete();
    req[3] = 1'b1; addr[3] = 23'h7FFF3C;
    tick(); tick();
    req[3] = 1'b0;
    repeat (25) tick();
    chk("t6_count", vlog.size(), 1);
    if (vlog.size() >= 1) chk("t6_ch", vlog[0], 3);

    // Randomized traffic
    drv_en = 1'b1;
    repeat (3000) tick();
    drv_en = 1'b0;
    req = '0; ry = 1'b1;
    repeat (30) tick();
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
